// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: the operand is split into STAGES chunks,
// each chunk being a chain of SEG-bit carry-select segments, with valid/ready flow control.
module csel_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int SEG    = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int C    = WIDTH / STAGES;
  localparam int NSEG = C / SEG;
  localparam int L    = STAGES - 1;

  if (SEG < 1 || STAGES < 1 || STAGES > WIDTH / SEG || (WIDTH % (STAGES * SEG)) != 0) begin : g_bad_params
    $error("csel_adder_pipe: illegal WIDTH/SEG/STAGES combination");
  end

  // Segment 0 ripples from the real chunk carry; later segments pick a precomputed sum.
  function automatic logic [C:0] chunk_add(input logic [C-1:0] x, input logic [C-1:0] y,
                                           input logic ci);
    logic [C-1:0] s;
    logic         c;
    logic [SEG:0] r0;
    logic [SEG:0] r1;
    s = '0;
    c = ci;
    for (int i = 0; i < NSEG; i++) begin
      if (i == 0) begin
        r0 = {1'b0, x[i*SEG +: SEG]} + {1'b0, y[i*SEG +: SEG]} + {{SEG{1'b0}}, c};
        s[i*SEG +: SEG] = r0[SEG-1:0];
        c = r0[SEG];
      end else begin
        r0 = {1'b0, x[i*SEG +: SEG]} + {1'b0, y[i*SEG +: SEG]};
        r1 = {1'b0, x[i*SEG +: SEG]} + {1'b0, y[i*SEG +: SEG]} + {{SEG{1'b0}}, 1'b1};
        s[i*SEG +: SEG] = c ? r1[SEG-1:0] : r0[SEG-1:0];
        c = c ? r1[SEG] : r0[SEG];
      end
    end
    return {c, s};
  endfunction

  logic              advance;
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] v_nx;
  logic [STAGES-1:0] c_nx;
  logic [WIDTH-1:0]  a_p [STAGES];
  logic [WIDTH-1:0]  b_p [STAGES];
  logic [WIDTH-1:0]  s_p [STAGES];
  logic              c_p [STAGES];
  logic [WIDTH-1:0]  a_nx [STAGES];
  logic [WIDTH-1:0]  b_nx [STAGES];
  logic [WIDTH-1:0]  s_nx [STAGES];

  assign out_valid = vld_p[L];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] si;
    logic [WIDTH-1:0] sk;
    logic             ci;
    logic [C:0]       r;

    // Stage k input: chunk 0 sees conditioned operands, later chunks see stage k-1.
    if (k == 0) begin : g_first
      assign ai      = a;
      assign bi      = sub ? ~b : b;
      assign ci      = sub | cin;
      assign si      = '0;
      assign v_nx[k] = in_valid;
    end else begin : g_next
      assign ai      = a_p[k-1];
      assign bi      = b_p[k-1];
      assign ci      = c_p[k-1];
      assign si      = s_p[k-1];
      assign v_nx[k] = vld_p[k-1];
    end

    assign r = chunk_add(ai[k*C +: C], bi[k*C +: C], ci);

    always_comb begin
      sk = si;
      sk[k*C +: C] = r[C-1:0];
    end

    assign a_nx[k] = ai;
    assign b_nx[k] = bi;
    assign s_nx[k] = sk;
    assign c_nx[k] = r[C];
  end

  // Stage registers: valid bits are reset, operand/partial-sum payload is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (advance) begin
      vld_p <= v_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < L; k++) begin
        a_p[k] <= a_nx[k];
        b_p[k] <= b_nx[k];
        s_p[k] <= s_nx[k];
        c_p[k] <= c_nx[k];
      end
    end
  end

  // Output stage: a bubble advancing in leaves the previous result and flags untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (advance && v_nx[L]) begin
      sum      <= s_nx[L];
      cout     <= c_nx[L];
      overflow <= (a_nx[L][WIDTH-1] == b_nx[L][WIDTH-1]) &&
                  (s_nx[L][WIDTH-1] != a_nx[L][WIDTH-1]);
      zero     <= ~|s_nx[L];
    end
  end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe: a 32-bit/2-stage instance and a 16-bit/1-stage
// instance are exercised in turn against an integer-arithmetic reference model.
module tb_csel_adder_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, cin, sub, sel;
  logic [31:0] a_d, b_d;

  logic        rdy0, ov0, co0, of0, z0;
  logic [31:0] sum0;
  logic        rdy1, ov1, co1, of1, z1;
  logic [15:0] sum1;

  csel_adder_pipe #(.WIDTH(32), .SEG(8), .STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(rdy0),
    .a(a_d), .b(b_d), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .sum(sum0), .cout(co0),
    .overflow(of0), .zero(z0));

  csel_adder_pipe #(.WIDTH(16), .SEG(4), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(rdy1),
    .a(a_d[15:0]), .b(b_d[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .cout(co1),
    .overflow(of1), .zero(z1));

  logic        rdy_s, ov_s, co_s, of_s, z_s;
  logic [31:0] sum_s;
  assign rdy_s = sel ? rdy1 : rdy0;
  assign ov_s  = sel ? ov1  : ov0;
  assign co_s  = sel ? co1  : co0;
  assign of_s  = sel ? of1  : of0;
  assign z_s   = sel ? z1   : z0;
  assign sum_s = sel ? {16'h0, sum1} : sum0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          stamp;
    bit          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   rnd_on;
  bit   saw_drop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic at width w.
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic c, input logic s);
    exp_t   e;
    longint m, lim, ua, ub, sa, sb, u, r;
    m   = (longint'(1) << w) - 1;
    lim = longint'(1) << (w - 1);
    ua  = longint'(av) & m;
    ub  = longint'(bv) & m;
    sa  = (ua >= lim) ? ua - (lim << 1) : ua;
    sb  = (ub >= lim) ? ub - (lim << 1) : ub;
    if (s) begin
      u      = ua - ub;
      r      = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      u      = ua + ub + longint'(c);
      r      = sa + sb + longint'(c);
      e.cout = (u > m);
    end
    e.sum   = 32'(u & m);
    e.zero  = ((u & m) == 0);
    e.ovf   = (r >= lim) || (r < -lim);
    e.stamp = 0;
    e.lat   = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n === 1'b1 && ov0 === 1'b1 && out_ready === 1'b1) begin
      if (q0.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL w32 spurious: got out_valid=1 sum=%0h expected no result", sum0);
      end else begin
        e = q0.pop_front();
        chk("w32 sum", sum0, e.sum);
        chk("w32 cout", 32'(co0), 32'(e.cout));
        chk("w32 overflow", 32'(of0), 32'(e.ovf));
        chk("w32 zero", 32'(z0), 32'(e.zero));
        if (e.lat) chk("w32 latency", 32'(cyc - e.stamp), 32'd2);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n === 1'b1 && ov1 === 1'b1 && out_ready === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL w16 spurious: got out_valid=1 sum=%0h expected no result", sum1);
      end else begin
        e = q1.pop_front();
        chk("w16 sum", {16'h0, sum1}, e.sum);
        chk("w16 cout", 32'(co1), 32'(e.cout));
        chk("w16 overflow", 32'(of1), 32'(e.ovf));
        chk("w16 zero", 32'(z1), 32'(e.zero));
        if (e.lat) chk("w16 latency", 32'(cyc - e.stamp), 32'd1);
      end
    end
  end

  // Offer one beat, holding it stable until accepted; expected result is queued at handshake.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic c,
                      input logic s, input bit lat);
    bit   done;
    exp_t e;
    done = 1'b0;
    a_d = av; b_d = bv; cin = c; sub = s; in_valid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (rdy_s) begin
        e = model(sel ? 16 : 32, av, bv, c, s);
        e.stamp = cyc;
        e.lat   = lat;
        if (sel) q1.push_back(e); else q0.push_back(e);
        n_vec++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL send timeout: got in_ready=0 for 64 cycles expected acceptance");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if ((sel ? q1.size() : q0.size()) == 0) break;
    end
    chk(sel ? "w16 drain" : "w32 drain", 32'(sel ? q1.size() : q0.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1 << (w - 1);
      3:       return (32'd1 << (w - 1)) - 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_suite(input bit d);
    int          w;
    logic [31:0] msk, half, msb;
    sel  = d;
    w    = d ? 16 : 32;
    msk  = d ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    half = (32'd1 << (w / 2)) - 32'd1;
    msb  = 32'd1 << (w - 1);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases, each with a latency check.
    send(half, 32'd1, 1'b0, 1'b0, 1'b1);
    send(msk, 32'd0, 1'b1, 1'b0, 1'b1);
    send(msb - 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    send(msb, 32'd1, 1'b0, 1'b1, 1'b1);
    send(32'd3, 32'd5, 1'b1, 1'b1, 1'b1);
    send(32'd5, 32'd5, 1'b1, 1'b1, 1'b1);
    drain();

    // Backpressure: out_ready low during relative cycles 2..5.
    saw_drop = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'(i + 1), 32'(i + 1), 1'b0, 1'b0, 1'b0);
      end
      begin
        for (int c = 0; c < 8; c++) begin
          out_ready = !(c >= 2 && c <= 5);
          @(negedge clk);
          if (!rdy_s) saw_drop = 1'b1;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    chk(d ? "w16 in_ready drop" : "w32 in_ready drop", 32'(saw_drop), 32'd1);
    drain();

    // Asynchronous reset with beats in flight.
    send(32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    #1;
    chk(d ? "w16 inflight valid" : "w32 inflight valid", 32'(ov_s), 32'd1);
    rst_n = 1'b0;
    #1;
    chk(d ? "w16 rst out_valid" : "w32 rst out_valid", 32'(ov_s), 32'd0);
    chk(d ? "w16 rst sum" : "w32 rst sum", sum_s, 32'd0);
    chk(d ? "w16 rst flags" : "w32 rst flags", {29'd0, co_s, of_s, z_s}, 32'd0);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk(d ? "w16 stale" : "w32 stale", 32'(ov_s), 32'd0);
    end
    @(posedge clk); #1;
    send(32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
    drain();

    // Randomized traffic with random gaps and random backpressure.
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(pick(w), pick(w), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got no completion expected finish within 20000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    a_d = '0; b_d = '0; cin = 1'b0; sub = 1'b0;
    #12;
    chk("reset w32 out_valid", 32'(ov0), 32'd0);
    chk("reset w32 sum", sum0, 32'd0);
    chk("reset w32 flags", {29'd0, co0, of0, z0}, 32'd0);
    chk("reset w16 out_valid", 32'(ov1), 32'd0);
    chk("reset w16 sum", {16'h0, sum1}, 32'd0);
    chk("reset w16 flags", {29'd0, co1, of1, z1}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle w32 in_ready", 32'(rdy0), 32'd1);
    chk("idle w16 in_ready", 32'(rdy1), 32'd1);
    run_suite(1'b0);
    run_suite(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, pipelined successor to the team's 32-bit carry-select adder.
- Operand width is split into STAGES pipeline chunks.
- Each chunk is a carry-select adder of SEG-bit segments: dual sums for carry-in 0 and 1, muxed by the incoming carry.
- Adds a subtract mode, valid/ready handshake with backpressure, and a registered result with cout/overflow/zero flags.
- Sits between the operand-fetch stage and the writeback register in the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; WIDTH % (STAGES*SEG) == 0.
- SEG, 8, carry-select segment width in bits.
- STAGES, 2, pipeline depth; 1 <= STAGES <= WIDTH/SEG.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in, add mode only
- sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1; cin ignored)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; in sub mode 1 means no borrow
- overflow  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (async, rst_n=0): all pipeline valid bits, sum, cout, overflow and zero clear to 0 immediately.
  - in_ready is 1 while in reset deasserted-state logic allows; it is combinational from the stall term.
  - A reset mid-operation discards all in-flight beats; none reappear.
- Operand conditioning at acceptance: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Chunk k (k = 0..STAGES-1) covers bits [k*C +: C], with C = WIDTH/STAGES.
- Within a chunk, segment 0 uses the real chunk carry-in. Every other segment computes both carry-in 0 and carry-in 1 results; the previous segment's carry-out selects one.
- Pipeline:
  - Stage k register holds the remaining unprocessed high operand bits, the finished low sum bits, the chunk carry, and a valid bit.
  - Chunk 0 is computed combinationally at input and registered into stage 0.
  - Chunk k is computed from the stage k-1 register and registered into stage k.
- Latency: exactly STAGES cycles from handshake (in_valid & in_ready) to out_valid, when out_ready is held 1.
- Throughput: one result per cycle.
- Flow control:
  - advance = !out_valid | out_ready. When advance=0, every stage holds, including empty (bubble) stages.
  - in_ready = advance.
  - A beat offered while in_ready=0 is not taken; the source holds a, b, cin, sub stable.
- Output stage registers:
  - sum and cout = carry out of bit WIDTH-1.
  - overflow = (A[W-1] == b_eff[W-1]) & (sum[W-1] != A[W-1]).
  - zero = ~|sum.
  - Output registers update only on advance. When a bubble advances in, out_valid goes 0 and sum/flags keep their previous values.
- Simultaneous input accept and output pop in one cycle is legal; no bubble is inserted.
- Wrap-around: results are modulo 2^WIDTH; carry is reported only via cout.
- out_valid is never deasserted by the block while out_ready=0.
- Parameter check: an illegal WIDTH/SEG/STAGES combination fails elaboration.

Test Plan:
- Reset, then add 0x0000FFFF + 0x00000001, cin=0, out_ready=1:
  - sum=0x00010000, cout=0, overflow=0, zero=0.
  - out_valid rises exactly 2 cycles after accept.
- Carry across the chunk boundary: 0xFFFFFFFF + 0x00000000, cin=1 -> sum=0x00000000, cout=1, zero=1, overflow=0.
- Signed overflow:
  - 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, overflow=1, cout=0.
  - sub: 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, overflow=1, cout=1.
- Subtract borrow: 0x00000003 - 0x00000005 -> sum=0xFFFFFFFE, cout=0, overflow=0.
  - The cin=1 input must be ignored in this case.
- Backpressure:
  - Stream 4 back-to-back beats (i+1)+(i+1), i = 0..3, with out_ready=0 for cycles 2-5.
  - in_ready drops; results 2, 4, 6, 8 are delivered in order, none lost or duplicated.
- Async reset asserted while 2 beats are in flight:
  - out_valid and sum clear immediately.
  - No stale result appears after release; the next beat 1+1 -> 2 arrives with nominal latency.
  - Repeat the full suite with STAGES=1, SEG=4, WIDTH=16.
